// File: rtl/c16_loader_pkg.sv
// Shared types and constants for the C16 PRG loader.
// Pointer-patch table: BASIC/KERNAL end-of-program vectors.
package c16_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_LO,
    HDR_HI,
    DATA,
    PATCH
  } state_e;

  localparam int PATCH_N = 8;

  localparam logic [7:0] PATCH_ADDR [0:PATCH_N-1] = '{
    8'h2D, 8'h2E, 8'h2F, 8'h30,
    8'h31, 8'h32, 8'hAE, 8'hAF
  };

endpackage

// File: rtl/c16_prg_loader.sv
// Streams a PRG download into C16 RAM port A and
// patches the end-of-program pointers afterwards.
module c16_prg_loader
  import c16_loader_pkg::*;
#(
  parameter logic [7:0]  PRG_INDEX = 8'd1,
  parameter int unsigned PATCH_GAP = 1
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [15:0] dl_addr,
  output logic [7:0]  dl_data,
  output logic        dl_wr,
  output logic        busy,
  output logic        done,
  output logic [15:0] end_addr,
  output logic [1:0]  err
);

  localparam logic [1:0] GAP = 2'(PATCH_GAP);
  localparam logic [2:0] LAST = 3'(PATCH_N - 1);

  state_e      state_q;
  logic        act_q;
  logic [15:0] addr_q;
  logic        wrap_q;
  logic [2:0]  idx_q;
  logic [1:0]  gap_q;
  logic        pfin_q;
  logic [15:0] dl_addr_q;
  logic [7:0]  dl_data_q;
  logic        dl_wr_q;
  logic        busy_q;
  logic        done_q;
  logic [15:0] end_addr_q;
  logic [1:0]  err_q;

  logic act;
  logic rise;
  logic fall;
  logic wr_ok;

  assign act   = ioctl_download &&
                 (ioctl_index == PRG_INDEX);
  assign rise  = act && !act_q;
  assign fall  = !act && act_q;
  assign wr_ok = act && ioctl_wr;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      act_q      <= 1'b0;
      addr_q     <= '0;
      wrap_q     <= 1'b0;
      idx_q      <= '0;
      gap_q      <= '0;
      pfin_q     <= 1'b0;
      dl_addr_q  <= '0;
      dl_data_q  <= '0;
      dl_wr_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      end_addr_q <= '0;
      err_q      <= '0;
    end else begin
      act_q   <= act;
      dl_wr_q <= 1'b0;
      done_q  <= 1'b0;
      // A new download always restarts, even mid-patch.
      if (rise) begin
        state_q <= HDR_LO;
        err_q   <= '0;
        busy_q  <= 1'b1;
        wrap_q  <= 1'b0;
        pfin_q  <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
          end
          HDR_LO: begin
            if (fall) begin
              state_q  <= IDLE;
              err_q[0] <= 1'b1;
              busy_q   <= 1'b0;
            end else if (wr_ok &&
                         ioctl_addr == 25'd0) begin
              addr_q[7:0] <= ioctl_dout;
              state_q     <= HDR_HI;
            end
          end
          HDR_HI: begin
            if (fall) begin
              state_q  <= IDLE;
              err_q[0] <= 1'b1;
              busy_q   <= 1'b0;
            end else if (wr_ok &&
                         ioctl_addr == 25'd1) begin
              addr_q[15:8] <= ioctl_dout;
              state_q      <= DATA;
            end
          end
          DATA: begin
            if (fall) begin
              state_q    <= PATCH;
              end_addr_q <= addr_q;
              idx_q      <= '0;
              gap_q      <= '0;
              pfin_q     <= 1'b0;
            end else if (wr_ok) begin
              if (wrap_q) begin
                err_q[1] <= 1'b1;
              end else begin
                dl_wr_q   <= 1'b1;
                dl_addr_q <= addr_q;
                dl_data_q <= ioctl_dout;
                addr_q    <= addr_q + 16'd1;
                if (addr_q == 16'hFFFF)
                  wrap_q <= 1'b1;
              end
            end
          end
          PATCH: begin
            if (pfin_q) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              pfin_q  <= 1'b0;
              state_q <= IDLE;
            end else if (gap_q == 2'd0) begin
              dl_wr_q   <= 1'b1;
              dl_addr_q <= {8'h00, PATCH_ADDR[idx_q]};
              dl_data_q <= idx_q[0] ?
                           end_addr_q[15:8] :
                           end_addr_q[7:0];
              gap_q     <= GAP;
              idx_q     <= idx_q + 3'd1;
              if (idx_q == LAST)
                pfin_q <= 1'b1;
            end else begin
              gap_q <= gap_q - 2'd1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign dl_addr  = dl_addr_q;
  assign dl_data  = dl_data_q;
  assign dl_wr    = dl_wr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign end_addr = end_addr_q;
  assign err      = err_q;

endmodule

// File: tb/tb_c16_prg_loader.sv
// Directed bench for c16_prg_loader: PRG parse,
// pointer patch, short/wrapped files, foreign index, reset.
module tb_c16_prg_loader;

  logic        clk;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [15:0] dl_addr;
  logic [7:0]  dl_data;
  logic        dl_wr;
  logic        busy;
  logic        done;
  logic [15:0] end_addr;
  logic [1:0]  err;

  c16_prg_loader dut (
    .clk_sys        (clk),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .dl_addr        (dl_addr),
    .dl_data        (dl_data),
    .dl_wr          (dl_wr),
    .busy           (busy),
    .done           (done),
    .end_addr       (end_addr),
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] wa [0:255];
  logic [7:0]  wd [0:255];
  int          wc [0:255];
  int          nw = 0;
  int          ndone = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dl_wr && nw < 256) begin
      wa[nw] = dl_addr;
      wd[nw] = dl_data;
      wc[nw] = cyc;
      nw = nw + 1;
    end
    if (done) ndone = ndone + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [7:0] idx);
    ioctl_download = 1'b1;
    ioctl_index    = idx;
    tick();
  endtask

  task automatic stop();
    ioctl_download = 1'b0;
    tick();
  endtask

  task automatic wrb(input logic [24:0] a,
                     input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk({tag, "_timeout"}, 1, 0);
    tick();
    tick();
  endtask

  int base;
  int d0;
  logic [7:0] lo;
  logic [7:0] hi;
  logic [7:0] pa [0:7];

  initial begin
    pa[0] = 8'h2D; pa[1] = 8'h2E;
    pa[2] = 8'h2F; pa[3] = 8'h30;
    pa[4] = 8'h31; pa[5] = 8'h32;
    pa[6] = 8'hAE; pa[7] = 8'hAF;
    reset          = 1'b1;
    ioctl_download = 1'b0;
    ioctl_index    = 8'd0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    tick();
    tick();
    chk("rst_dl_addr", 32'(dl_addr), 0);
    chk("rst_dl_data", 32'(dl_data), 0);
    chk("rst_dl_wr", 32'(dl_wr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_end", 32'(end_addr), 0);
    chk("rst_err", 32'(err), 0);
    reset = 1'b0;
    tick();

    // PRG {01,10,AA,BB,CC}
    base = nw;
    d0   = ndone;
    start(8'd1);
    chk("t1_busy", 32'(busy), 1);
    wrb(25'd0, 8'h01);
    wrb(25'd1, 8'h10);
    ioctl_addr = 25'd2;
    ioctl_dout = 8'hAA;
    ioctl_wr   = 1'b1;
    tick();
    chk("t1_lat_wr", 32'(dl_wr), 1);
    chk("t1_lat_addr", 32'(dl_addr), 32'h1001);
    chk("t1_lat_data", 32'(dl_data), 32'hAA);
    ioctl_wr = 1'b0;
    tick();
    chk("t1_no_stretch", 32'(dl_wr), 0);
    wrb(25'd3, 8'hBB);
    wrb(25'd4, 8'hCC);
    stop();
    wait_idle("t1");
    chk("t1_nw", 32'(nw - base), 11);
    chk("t1_w0a", 32'(wa[base]), 32'h1001);
    chk("t1_w1a", 32'(wa[base+1]), 32'h1002);
    chk("t1_w1d", 32'(wd[base+1]), 32'hBB);
    chk("t1_w2a", 32'(wa[base+2]), 32'h1003);
    chk("t1_w2d", 32'(wd[base+2]), 32'hCC);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t1_pa%0d", i),
          32'(wa[base+3+i]), 32'(pa[i]));
      chk($sformatf("t1_pd%0d", i),
          32'(wd[base+3+i]),
          (i % 2 == 0) ? 32'h04 : 32'h10);
    end
    chk("t1_gap", 32'(wc[base+4] - wc[base+3]), 2);
    chk("t1_gap7", 32'(wc[base+10] - wc[base+9]), 2);
    chk("t1_done", 32'(ndone - d0), 1);
    chk("t1_end", 32'(end_addr), 32'h1004);
    chk("t1_err", 32'(err), 0);
    chk("t1_busy_end", 32'(busy), 0);

    // header-only {00,40}
    base = nw;
    d0   = ndone;
    start(8'd1);
    wrb(25'd0, 8'h00);
    wrb(25'd1, 8'h40);
    stop();
    wait_idle("t2");
    chk("t2_nw", 32'(nw - base), 8);
    chk("t2_w0a", 32'(wa[base]), 32'h002D);
    chk("t2_w0d", 32'(wd[base]), 32'h00);
    chk("t2_w1d", 32'(wd[base+1]), 32'h40);
    chk("t2_w7a", 32'(wa[base+7]), 32'h00AF);
    chk("t2_end", 32'(end_addr), 32'h4000);
    chk("t2_done", 32'(ndone - d0), 1);

    // 1-byte file {01}
    base = nw;
    d0   = ndone;
    start(8'd1);
    wrb(25'd0, 8'h01);
    stop();
    repeat (30) tick();
    chk("t3_nw", 32'(nw - base), 0);
    chk("t3_err", 32'(err), 32'b01);
    chk("t3_busy", 32'(busy), 0);
    chk("t3_done", 32'(ndone - d0), 0);

    // load at FFFE with 4 payload bytes
    base = nw;
    d0   = ndone;
    start(8'd1);
    wrb(25'd0, 8'hFE);
    wrb(25'd1, 8'hFF);
    wrb(25'd2, 8'h11);
    wrb(25'd3, 8'h22);
    wrb(25'd4, 8'h33);
    wrb(25'd5, 8'h44);
    stop();
    wait_idle("t4");
    chk("t4_nw", 32'(nw - base), 10);
    chk("t4_w0a", 32'(wa[base]), 32'hFFFE);
    chk("t4_w1a", 32'(wa[base+1]), 32'hFFFF);
    chk("t4_w1d", 32'(wd[base+1]), 32'h22);
    chk("t4_p0a", 32'(wa[base+2]), 32'h002D);
    chk("t4_p0d", 32'(wd[base+2]), 32'h00);
    chk("t4_err", 32'(err), 32'b10);
    chk("t4_end", 32'(end_addr), 32'h0000);
    chk("t4_done", 32'(ndone - d0), 1);

    // foreign index 2, 16 bytes
    base = nw;
    d0   = ndone;
    start(8'd2);
    for (int i = 0; i < 16; i++) begin
      wrb(25'(i), 8'(i * 3 + 1));
      if (i == 4) chk("t5_busy_mid", 32'(busy), 0);
    end
    stop();
    repeat (30) tick();
    chk("t5_nw", 32'(nw - base), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_done", 32'(ndone - d0), 0);

    // reset during PATCH after 3rd patch write
    base = nw;
    d0   = ndone;
    start(8'd1);
    wrb(25'd0, 8'h00);
    wrb(25'd1, 8'h20);
    wrb(25'd2, 8'h55);
    stop();
    begin
      int n;
      n = 0;
      while ((nw - base) < 4 && n < 100) begin
        tick();
        n++;
      end
      if (n >= 100) chk("t6_timeout", 1, 0);
    end
    reset = 1'b1;
    #1;
    chk("t6_dl_wr", 32'(dl_wr), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_done", 32'(done), 0);
    chk("t6_end", 32'(end_addr), 0);
    tick();
    reset = 1'b0;
    repeat (40) tick();
    chk("t6_nw", 32'(nw - base), 4);
    chk("t6_p2a", 32'(wa[base+3]), 32'h002F);
    chk("t6_ndone", 32'(ndone - d0), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got 1 exp 0");
    $fatal(1, "timeout");
  end

endmodule
